// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: a single-cycle pipeline port and a queued
// multi-cycle-unit port share one register-file write port.
module regfile_wb_arb #(
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_wen,
  input  logic [4:0]  i_pipe_waddr,
  input  logic [31:0] i_pipe_wdata,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_waddr,
  input  logic [31:0] i_mdu_wdata,
  output logic        o_mdu_ready,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  input  logic [4:0]  i_chk_addr1,
  input  logic [4:0]  i_chk_addr2,
  output logic        o_pend_hit,
  output logic        o_stall_req
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_rf_wen;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;

  logic             w_pipe_eff;
  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_wr;
  logic [4:0]       w_wr_addr;
  logic [31:0]      w_wr_data;
  logic             w_pend;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_pipe_eff = i_pipe_wen && (i_pipe_waddr != 5'd0);
  assign w_empty    = (r_count == CW'(0));
  assign w_ready    = (r_count < CW'(DEPTH));
  assign w_push     = i_mdu_valid && w_ready && (i_mdu_waddr != 5'd0);
  assign w_pop      = !w_pipe_eff && !w_empty;
  // A popped entry whose valid bit was cleared by a younger pipeline write still burns the slot.
  assign w_wr       = w_pipe_eff || (w_pop && r_vld[r_rptr]);
  assign w_wr_addr  = w_pipe_eff ? i_pipe_waddr : r_addr[r_rptr];
  assign w_wr_data  = w_pipe_eff ? i_pipe_wdata : r_data[r_rptr];

  // Next valid bits: push sets, pop clears, a matching pipeline write kills older entries.
  always_comb begin
    w_vld_nxt = r_vld;
    for (int i = 0; i < DEPTH; i++) begin
      w_vld_nxt[i] = (w_push && (r_wptr == PW'(i))) ? 1'b1 :
                     (w_pop && (r_rptr == PW'(i))) ? 1'b0 :
                     (w_pipe_eff && (r_addr[i] == i_pipe_waddr)) ? 1'b0 : r_vld[i];
    end
  end

  // Hazard lookup against every still-valid queued destination.
  always_comb begin
    w_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend = w_pend | (r_vld[i] &
               (((i_chk_addr1 != 5'd0) && (r_addr[i] == i_chk_addr1)) ||
                ((i_chk_addr2 != 5'd0) && (r_addr[i] == i_chk_addr2))));
    end
  end

  // Queue payload storage; contents are only meaningful under r_vld.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= i_mdu_waddr;
      r_data[r_wptr] <= i_mdu_wdata;
    end
  end

  // Queue control, starvation tracking and registered write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else begin
      r_vld   <= w_vld_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? PW'(0) : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? PW'(0) : r_rptr + PW'(1);
      end
      if (!w_empty && w_pipe_eff) begin
        r_starve <= (r_starve == SW'(STARVE)) ? r_starve : r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
      r_rf_wen <= w_wr;
      if (w_wr) begin
        r_rf_waddr <= w_wr_addr;
        r_rf_wdata <= w_wr_data;
      end
    end
  end

  assign o_mdu_ready = w_ready;
  assign o_pend_hit  = w_pend;
  assign o_stall_req = (r_count == CW'(DEPTH)) || (r_starve == SW'(STARVE));
  assign o_rf_wen    = r_rf_wen;
  assign o_rf_waddr  = r_rf_waddr;
  assign o_rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: a queue-level reference model predicts
// every output; a monitor compares the registered write port cycle by cycle.
module tb_regfile_wb_arb;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pipe_wen = 1'b0;
  logic [4:0]  i_pipe_waddr = 5'd0;
  logic [31:0] i_pipe_wdata = 32'd0;
  logic        i_mdu_valid = 1'b0;
  logic [4:0]  i_mdu_waddr = 5'd0;
  logic [31:0] i_mdu_wdata = 32'd0;
  logic [4:0]  i_chk_addr1 = 5'd0;
  logic [4:0]  i_chk_addr2 = 5'd0;
  logic        o_mdu_ready, o_rf_wen, o_pend_hit, o_stall_req;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;

  regfile_wb_arb #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_pipe_wen(i_pipe_wen), .i_pipe_waddr(i_pipe_waddr), .i_pipe_wdata(i_pipe_wdata),
    .i_mdu_valid(i_mdu_valid), .i_mdu_waddr(i_mdu_waddr), .i_mdu_wdata(i_mdu_wdata),
    .o_mdu_ready(o_mdu_ready), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata), .i_chk_addr1(i_chk_addr1), .i_chk_addr2(i_chk_addr2),
    .o_pend_hit(o_pend_hit), .o_stall_req(o_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic wen; logic [4:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] a; logic [31:0] d; bit v; } ent_t;

  exp_t        sb[$];
  ent_t        mq[$];
  int          m_starve = 0;
  logic [4:0]  m_last_addr = 5'd0;
  logic [31:0] m_last_data = 32'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check state-derived outputs, advance the model.
  task automatic step(input logic r, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] c1, input logic [4:0] c2);
    bit   ready, pend, stall, eff, empty, wen;
    ent_t e;
    exp_t x;
    @(negedge clk);
    i_reset = r; i_pipe_wen = pw; i_pipe_waddr = pa; i_pipe_wdata = pd;
    i_mdu_valid = mv; i_mdu_waddr = ma; i_mdu_wdata = md;
    i_chk_addr1 = c1; i_chk_addr2 = c2;
    #1;
    ready = (mq.size() < DEPTH);
    stall = (mq.size() == DEPTH) || (m_starve == STARVE);
    pend  = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].v && ((c1 != 5'd0 && mq[i].a == c1) || (c2 != 5'd0 && mq[i].a == c2))) pend = 1'b1;
    end
    chk("mdu_ready", {31'd0, o_mdu_ready}, {31'd0, ready});
    chk("stall_req", {31'd0, o_stall_req}, {31'd0, stall});
    chk("pend_hit",  {31'd0, o_pend_hit},  {31'd0, pend});
    wen = 1'b0;
    if (r) begin
      mq.delete();
      m_starve = 0;
      m_last_addr = 5'd0;
      m_last_data = 32'd0;
    end else begin
      eff   = pw && (pa != 5'd0);
      empty = (mq.size() == 0);
      if (eff) begin
        wen = 1'b1; m_last_addr = pa; m_last_data = pd;
        foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
      end else if (!empty) begin
        e = mq.pop_front();
        if (e.v) begin wen = 1'b1; m_last_addr = e.a; m_last_data = e.d; end
      end
      if (!empty && eff) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else m_starve = 0;
      if (mv && ready && ma != 5'd0) begin
        e.a = ma; e.d = md; e.v = 1'b1;
        mq.push_back(e);
      end
    end
    x.cyc = cyc + 1; x.wen = wen; x.addr = m_last_addr; x.data = m_last_data;
    sb.push_back(x);
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, c1, 5'd0);
  endtask

  // Monitor: the write port is compared against the scoreboard every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_checks++; n_errors++;
        $display("FAIL sb_stale cycle=%0d actual=unchecked required=cycle %0d", cyc, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("rf_wen",   {31'd0, o_rf_wen}, {31'd0, e.wen});
        chk("rf_waddr", {27'd0, o_rf_waddr}, {27'd0, e.addr});
        chk("rf_wdata", o_rf_wdata, e.data);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2, 5'd4, 5'd0);
    idle(1, 5'd0);
    // single pipeline write on an idle queue
    step(1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2, 5'd0);
    // starvation: x7 queued behind a busy pipeline
    step(1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 5'd3, 32'h301 + k, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(2, 5'd7);
    // full queue back-pressure
    step(1'b0, 1'b1, 5'd3, 32'h400, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd3, 32'h401, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd3, 32'h402, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0,   1'b1, 5'd12, 32'hC0, 5'd12, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0,   1'b1, 5'd12, 32'hC0, 5'd12, 5'd0);
    idle(3, 5'd12);
    // WAW: younger pipeline write kills the queued x9
    step(1'b0, 1'b1, 5'd4, 32'h500, 1'b1, 5'd9, 32'h22, 5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h33,  1'b0, 5'd0, 32'd0,  5'd9, 5'd0);
    idle(2, 5'd9);
    // x0 on both ports
    step(1'b0, 1'b1, 5'd6, 32'h600, 1'b1, 5'd0, 32'h77, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd6, 32'h601, 1'b1, 5'd13, 32'h88, 5'd13, 5'd0);
    step(1'b0, 1'b1, 5'd0, 32'h602, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    idle(1, 5'd0);
    // reset with two queued entries and a live pipeline request
    step(1'b0, 1'b1, 5'd6, 32'h700, 1'b1, 5'd14, 32'hE0, 5'd14, 5'd0);
    step(1'b0, 1'b1, 5'd6, 32'h701, 1'b1, 5'd15, 32'hF0, 5'd14, 5'd15);
    step(1'b1, 1'b1, 5'd6, 32'h702, 1'b1, 5'd16, 32'h1F, 5'd14, 5'd15);
    idle(3, 5'd14);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(2, 5'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
